imem_boot_ctrl: RTL and testbench

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_boot_ctrl.sv | 104 ++++++++++
 tb/tb_imem_boot_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - instruction memory boot loader: streams program bytes into IMEM
// and holds the core in stall until a load completes.
module imem_boot_ctrl #(
  parameter int N   = 10,
  parameter int M   = 1024,
  parameter int TMO = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N:0]   len_i,
  input  logic         rx_valid_i,
  input  logic [7:0]   rx_data_i,
  output logic         rx_ready_o,
  input  logic [N-1:0] fetch_addr_i,
  output logic [N-1:0] mem_addr_o,
  output logic         mem_we_o,
  output logic [7:0]   mem_wdata_o,
  output logic         cpu_stall_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [1:0]   err_code_o,
  output logic [7:0]   checksum_o
);

  localparam int TW = $clog2(TMO + 1);
  localparam logic [N:0]    LEN_MAX  = (N+1)'(M);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t        state, state_nx;
  logic [N:0]    cnt;
  logic [N:0]    len_q;
  logic [TW-1:0] timer;
  logic [7:0]    csum;
  logic [1:0]    code;

  logic len_ok, start_ok, accept, last_byte, expire;

  assign len_ok    = (len_i != '0) && (len_i <= LEN_MAX) && (len_i[1:0] == 2'b00);
  assign start_ok  = start_i && ((state == IDLE) || (state == ERR));
  assign accept    = (state == LOAD) && rx_valid_i;
  assign last_byte = (cnt == len_q - (N+1)'(1));
  // An acceptance in the expiry cycle takes priority over the timeout.
  assign expire    = (state == LOAD) && !rx_valid_i && (timer == TMO_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ERR: if (start_i) state_nx = len_ok ? LOAD : ERR;
      LOAD: begin
        if (accept && last_byte) state_nx = DONE;
        else if (expire)         state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      timer <= '0;
      csum  <= '0;
      code  <= 2'b00;
    end else begin
      state <= state_nx;
      if (start_ok && len_ok) begin
        cnt   <= '0;
        len_q <= len_i;
        timer <= '0;
        csum  <= '0;
        code  <= 2'b00;
      end else if (start_ok) begin
        code <= 2'b01;
      end else if (accept) begin
        cnt   <= cnt + (N+1)'(1);
        csum  <= csum + rx_data_i;
        timer <= '0;
      end else if (state == LOAD) begin
        timer <= timer + TW'(1);
        if (expire) code <= 2'b10;
      end
    end
  end

  always_comb begin
    rx_ready_o  = (state == LOAD);
    mem_we_o    = accept;
    mem_addr_o  = accept ? cnt[N-1:0] : fetch_addr_i;
    mem_wdata_o = accept ? rx_data_i : 8'h00;
    cpu_stall_o = (state != IDLE);
    busy_o      = (state == LOAD);
    done_o      = (state == DONE);
    err_o       = (state == ERR);
    err_code_o  = code;
    checksum_o  = csum;
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - randomized self-checking bench for imem_boot_ctrl against a
// transaction-level model of the loader.
module tb_imem_boot_ctrl;

  localparam int N   = 10;
  localparam int M   = 1024;
  localparam int TMO = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N:0]   len;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         rx_ready_o;
  logic [N-1:0] fetch_addr;
  logic [N-1:0] mem_addr_o;
  logic         mem_we_o;
  logic [7:0]   mem_wdata_o;
  logic         cpu_stall_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [1:0]   err_code_o;
  logic [7:0]   checksum_o;

  imem_boot_ctrl #(.N(N), .M(M), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start), .len_i(len),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready_o),
    .fetch_addr_i(fetch_addr), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .cpu_stall_o(cpu_stall_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o), .checksum_o(checksum_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a load is a byte quota; the loader is either loading, pulsing done,
  // parked in error, or idle.
  bit       m_load, m_done, m_err;
  bit [1:0] m_code;
  bit [7:0] m_sum;
  int       m_nbytes, m_len, m_idle;

  function automatic bit len_valid(input int l);
    return (l != 0) && (l <= M) && (l % 4 == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_load = 0; m_done = 0; m_err = 0; m_code = 0; m_sum = 0;
      m_nbytes = 0; m_idle = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_load) begin
      if (rx_valid) begin
        m_sum = m_sum + rx_data;
        m_nbytes++;
        m_idle = 0;
        if (m_nbytes == m_len) begin m_load = 0; m_done = 1; end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_load = 0; m_err = 1; m_code = 2'b10; end
      end
    end else if (start) begin
      if (len_valid(int'(len))) begin
        m_load = 1; m_err = 0; m_code = 0; m_sum = 0;
        m_nbytes = 0; m_idle = 0; m_len = int'(len);
      end else begin
        m_err = 1; m_code = 2'b01;
      end
    end
  end

  always @(negedge clk) begin
    logic acc;
    acc = m_load && rx_valid;
    chk("rx_ready", rx_ready_o, m_load);
    chk("mem_we", mem_we_o, acc);
    chk("mem_addr", mem_addr_o, acc ? N'(m_nbytes) : fetch_addr);
    chk("mem_wdata", mem_wdata_o, acc ? rx_data : 8'h00);
    chk("cpu_stall", cpu_stall_o, m_load || m_done || m_err);
    chk("busy", busy_o, m_load);
    chk("done", done_o, m_done);
    chk("err", err_o, m_err);
    chk("err_code", err_code_o, m_code);
    chk("checksum", checksum_o, m_sum);
  end

  int wlog[$];
  always @(negedge clk) if (mem_we_o) wlog.push_back(int'(mem_addr_o));

  task automatic tick();
    @(posedge clk);
    #1;
    fetch_addr = N'($urandom);
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len = (N+1)'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data = d;
    tick();
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  initial begin
    int quiet;
    bit seen;
    rst = 1'b1; start = 1'b0; len = '0; rx_valid = 1'b0; rx_data = 8'h00;
    fetch_addr = '0;
    repeat (3) tick();
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_stall", cpu_stall_o, 1'b0);
    chk("reset_code", err_code_o, 2'b00);
    rst = 1'b0;
    tick();

    // nominal load of 8 bytes
    wlog.delete();
    do_start(8);
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("nom_done", done_o, 1'b1);
    chk("nom_checksum", checksum_o, 8'h24);
    chk("nom_writes", wlog.size(), 8);
    for (int i = 0; i < wlog.size(); i++) chk("nom_addr", wlog[i], i);
    tick();
    chk("nom_stall_after", cpu_stall_o, 1'b0);
    chk("nom_checksum_hold", checksum_o, 8'h24);

    // throttled source
    wlog.delete();
    seen = 0;
    do_start(4);
    for (int c = 0; c < 60; c++) begin
      rx_valid = c[0];
      rx_data = 8'($urandom);
      tick();
      if (done_o) begin seen = 1; break; end
    end
    rx_valid = 1'b0;
    chk("thr_done_seen", seen, 1'b1);
    chk("thr_writes", wlog.size(), 4);
    for (int i = 0; i < wlog.size(); i++) chk("thr_addr", wlog[i], i);
    chk("thr_ready_after", rx_ready_o, 1'b0);
    tick();

    // bad lengths, then recovery
    wlog.delete();
    do_start(0);
    chk("bad0_code", err_code_o, 2'b01);
    do_start(6);
    chk("bad6_code", err_code_o, 2'b01);
    do_start(M + 4);
    chk("badM4_code", err_code_o, 2'b01);
    chk("bad_err", err_o, 1'b1);
    chk("bad_stall", cpu_stall_o, 1'b1);
    chk("bad_writes", wlog.size(), 0);
    do_start(4);
    chk("rec_code", err_code_o, 2'b00);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    chk("rec_done", done_o, 1'b1);
    chk("rec_checksum", checksum_o, 8'h46);
    tick();

    // timeout after 3 bytes
    do_start(8);
    for (int i = 0; i < 3; i++) send(8'h20);
    repeat (15) tick();
    chk("tmo_not_yet", err_o, 1'b0);
    tick();
    chk("tmo_err", err_o, 1'b1);
    chk("tmo_code", err_code_o, 2'b10);
    chk("tmo_checksum_hold", checksum_o, 8'h60);

    // byte on the 16th idle cycle wins over the timeout
    do_start(4);
    send(8'h01);
    repeat (15) tick();
    send(8'hAA);
    chk("bnd_no_err", err_o, 1'b0);
    chk("bnd_busy", busy_o, 1'b1);
    send(8'h02);
    send(8'h03);
    chk("bnd_done", done_o, 1'b1);
    tick();

    // reset mid-load, then IDLE passthrough
    do_start(16);
    for (int i = 0; i < 5; i++) send(8'h30);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    #1 rst = 1'b1;
    #1;
    chk("rstmid_we", mem_we_o, 1'b0);
    chk("rstmid_ready", rx_ready_o, 1'b0);
    chk("rstmid_busy", busy_o, 1'b0);
    chk("rstmid_stall", cpu_stall_o, 1'b0);
    chk("rstmid_checksum", checksum_o, 8'h00);
    tick();
    rst = 1'b0;
    rx_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fetch_addr = N'(k * 97 + 3);
      #1;
      chk("pass_addr", mem_addr_o, N'(k * 97 + 3));
      tick();
    end

    // randomized traffic
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom % 40) == 0;
      case ($urandom % 4)
        0: len = (N+1)'((($urandom % 8) + 1) * 4);
        1: len = (N+1)'($urandom % 40);
        2: len = (N+1)'(4);
        default: len = (N+1)'(M + ($urandom % 3) * 4);
      endcase
      if (quiet == 0 && ($urandom % 150) == 0) quiet = 14 + ($urandom % 6);
      if (quiet > 0) begin
        quiet--;
        rx_valid = 1'b0;
      end else begin
        rx_valid = ($urandom % 4) != 0;
      end
      rx_data = 8'($urandom);
      tick();
    end
    start = 1'b0;
    rx_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
